// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the drawer units and the framebuffer write-port
// arbiter: pixel field widths and the arbiter state encoding.
// -----------------------------------------------------------------------------
package draw_pkg;

    // Framebuffer pixel field widths, shared with every drawer unit.
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_DRAW    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection. The search begins at the
// requester after last_i and wraps around.
//
// Ports:
//   req_i   in  N_REQ   request vector
//   last_i  in  IDX_W   index of the most recently served requester
//   win_o   out IDX_W   winning requester index (valid when any_o)
//   any_o   out 1       at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;

    // Rotate so the search start lands at bit 0, take the lowest set bit,
    // then rotate the found position back into requester numbering.
    always_comb begin
        int unsigned start;
        int unsigned idx;
        int unsigned pos;
        int unsigned w;
        logic        found;

        rot   = '0;
        found = 1'b0;
        pos   = 0;
        any_o = |req_i;

        if (int'(last_i) == N_REQ - 1) begin
            start = 0;
        end else begin
            start = int'(last_i) + 1;
        end

        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = start + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            rot[IDX_W'(i)] = req_i[IDX_W'(idx)];
        end

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[IDX_W'(i)]) begin
                found = 1'b1;
                pos   = i;
            end
        end

        w = start + pos;
        if (w >= N_REQ) begin
            w = w - N_REQ;
        end
        win_o = IDX_W'(w);
    end

endmodule

// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
// Round-robin arbiter sharing the single VGA framebuffer write port between
// several drawer units. A granted drawer gets a one-cycle go pulse, then its
// pixel stream is routed to the adapter until it signals done or the
// watchdog revokes the grant.
//
// Ports:
//   clk          in  1          system clock
//   reset        in  1          asynchronous active-high reset
//   req          in  N_REQ      level request per drawer
//   x_in         in  N_REQ*9    packed pixel x per drawer
//   y_in         in  N_REQ*8    packed pixel y per drawer
//   color_in     in  N_REQ*3    packed pixel color per drawer
//   plot_in      in  N_REQ      pixel write strobe per drawer
//   done_in      in  N_REQ      drawer-finished strobe
//   gnt          out N_REQ      one-hot grant, zero when idle
//   go           out N_REQ      one-cycle start pulse to granted drawer
//   x_out        out 9          pixel x to VGA adapter
//   y_out        out 8          pixel y to VGA adapter
//   color_out    out 3          pixel color to VGA adapter
//   plot_out     out 1          pixel write strobe to VGA adapter
//   busy         out 1          arbiter not in IDLE
//   timeout_err  out 1          pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 131072
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*X_W-1:0] x_in,
    input  logic [N_REQ*Y_W-1:0] y_in,
    input  logic [N_REQ*C_W-1:0] color_in,
    input  logic [N_REQ-1:0]     plot_in,
    input  logic [N_REQ-1:0]     done_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     go,
    output logic [X_W-1:0]       x_out,
    output logic [Y_W-1:0]       y_out,
    output logic [C_W-1:0]       color_out,
    output logic                 plot_out,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_t       state_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [IDX_W-1:0] last_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] go_q;
    logic             busy_q;
    logic             terr_q;
    logic [WD_W-1:0]  wd_q;

    logic [IDX_W-1:0] pick_idx_d;
    logic             pick_any_d;
    logic [N_REQ-1:0] pick_oh_d;

    logic [X_W-1:0] x_arr [N_REQ];
    logic [Y_W-1:0] y_arr [N_REQ];
    logic [C_W-1:0] c_arr [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (pick_idx_d),
        .any_o  (pick_any_d)
    );

    assign pick_oh_d = N_REQ'(1) << pick_idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            last_q    <= IDX_LAST;
            gnt_q     <= '0;
            go_q      <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            wd_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_d) begin
                        gnt_idx_q <= pick_idx_d;
                        gnt_q     <= pick_oh_d;
                        go_q      <= pick_oh_d;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    go_q    <= '0;
                    wd_q    <= '0;
                    state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    // Done has priority over an expiring watchdog. The counter
                    // is left alone on the exit cycle so it never wraps.
                    if (done_in[gnt_idx_q]) begin
                        state_q <= ST_RELEASE;
                    end else if (wd_q == WD_LAST) begin
                        terr_q  <= 1'b1;
                        state_q <= ST_RELEASE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    terr_q  <= 1'b0;
                    last_q  <= gnt_idx_q;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            x_arr[i] = x_in[i*X_W +: X_W];
            y_arr[i] = y_in[i*Y_W +: Y_W];
            c_arr[i] = color_in[i*C_W +: C_W];
        end
    end

    // Zero-latency pixel path, only open while drawing.
    always_comb begin
        x_out     = '0;
        y_out     = '0;
        color_out = '0;
        plot_out  = 1'b0;
        if (state_q == ST_DRAW) begin
            x_out     = x_arr[gnt_idx_q];
            y_out     = y_arr[gnt_idx_q];
            color_out = c_arr[gnt_idx_q];
            plot_out  = plot_in[gnt_idx_q];
        end
    end

    assign gnt         = gnt_q;
    assign go          = go_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_arbiter.sv
module tb_draw_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*9-1:0] x_in;
    logic [N*8-1:0] y_in;
    logic [N*3-1:0] color_in;
    logic [N-1:0]   plot_in;
    logic [N-1:0]   done_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   go;
    logic [8:0]     x_out;
    logic [7:0]     y_out;
    logic [2:0]     color_out;
    logic           plot_out;
    logic           busy;
    logic           timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    draw_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .x_in        (x_in),
        .y_in        (y_in),
        .color_in    (color_in),
        .plot_in     (plot_in),
        .done_in     (done_in),
        .gnt         (gnt),
        .go          (go),
        .x_out       (x_out),
        .y_out       (y_out),
        .color_out   (color_out),
        .plot_out    (plot_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        reset = 1'b1; req = '0; x_in = '0; y_in = '0; color_in = '0;
        plot_in = '0; done_in = '0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_go", 32'(go), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_plot", 32'(plot_out), 0);
        chk("rst_x", 32'(x_out), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        tick(); tick();
        reset = 1'b0;

        // ---- single request, 5 pixels, then done
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_go", 32'(go), 32'h1);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        tick();
        chk("t1_go_low", 32'(go), 0);
        chk("t1_gnt_held", 32'(gnt), 32'h1);
        for (int b = 0; b < 5; b++) begin
            x_in[8:0] = 9'(10 + b); y_in[7:0] = 8'(20 + b); color_in[2:0] = 3'(b + 1);
            plot_in = 4'b0001;
            #1;
            chk("t1_plot", 32'(plot_out), 1);
            chk("t1_x", 32'(x_out), 32'(10 + b));
            chk("t1_y", 32'(y_out), 32'(20 + b));
            chk("t1_c", 32'(color_out), 32'(b + 1));
            tick();
        end
        plot_in = '0; done_in = 4'b0001;
        #1;
        chk("t1_plot_off", 32'(plot_out), 0);
        tick();
        done_in = '0;
        chk("t1_rel_gnt", 32'(gnt), 32'h1);
        chk("t1_rel_busy", 32'(busy), 1);
        chk("t1_rel_plot", 32'(plot_out), 0);
        tick();
        chk("t1_idle_gnt", 32'(gnt), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // ---- fresh reset, all four requesting continuously
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_gnt", 32'(gnt), 32'(order[g]));
            chk("t2_go", 32'(go), 32'(order[g]));
            tick();
            chk("t2_onehot", 32'($countones(gnt)), 1);
            tick();
            done_in = order[g];
            tick();
            done_in = '0;
            chk("t2_rel_gnt", 32'(gnt), 32'(order[g]));
            tick();
            chk("t2_idle_gnt", 32'(gnt), 0);
        end
        req = '0;
        // last served is 0 now

        // ---- requester 2 granted, requester 1 spurious
        req = 4'b0100;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        req = 4'b0110;
        tick();
        x_in[17:9] = 9'd111; x_in[26:18] = 9'd222;
        plot_in = 4'b0110; done_in = 4'b0010;
        #1;
        chk("t3_plot", 32'(plot_out), 1);
        chk("t3_x", 32'(x_out), 222);
        plot_in = 4'b0010;
        #1;
        chk("t3_plot_spur", 32'(plot_out), 0);
        tick();
        chk("t3_gnt_kept", 32'(gnt), 32'h4);
        chk("t3_busy", 32'(busy), 1);
        plot_in = '0; done_in = 4'b0100;
        tick();
        done_in = '0;
        tick();
        chk("t3_idle", 32'(gnt), 0);
        tick();
        chk("t3_next", 32'(gnt), 32'h2);
        req = '0;
        tick();
        done_in = 4'b0010;
        tick();
        done_in = '0;
        tick();
        // last served is 1 now

        // ---- watchdog (TIMEOUT = 16)
        req = 4'b0011;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t4_no_terr", 32'(timeout_err), 0);
        end
        tick();
        chk("t4_terr", 32'(timeout_err), 1);
        chk("t4_rel_gnt", 32'(gnt), 32'h1);
        tick();
        chk("t4_terr_pulse", 32'(timeout_err), 0);
        chk("t4_idle", 32'(gnt), 0);
        tick();
        chk("t4_next", 32'(gnt), 32'h2);
        req = '0;
        for (int i = 0; i < 15; i++) tick();
        tick();
        done_in = 4'b0010;
        tick();
        done_in = '0;
        chk("t4_coinc_terr", 32'(timeout_err), 0);
        chk("t4_coinc_rel", 32'(gnt), 32'h2);
        tick();
        chk("t4_coinc_idle", 32'(gnt), 0);
        chk("t4_coinc_terr2", 32'(timeout_err), 0);
        // last served is 1 now

        // ---- asynchronous reset mid-DRAW
        req = 4'b0101;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h4);
        tick();
        plot_in = 4'b0100;
        #1;
        chk("t5_plot", 32'(plot_out), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_plot", 32'(plot_out), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        plot_in = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("t5_first", 32'(gnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
